// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
// Occupancy type, skid depth, FIFO read latency, stall counter width.
package fifo_pkg;

  typedef logic [1:0] occ_t;

  localparam int SKID_DEPTH = 2;
  localparam int RD_LAT     = 1;
  localparam int STALL_W    = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered skid buffer carrying data plus a last tag.
// Ports: clk, rst_n, push/push_data/push_last, pop -> occ, head_data, head_last.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output occ_t             occ,
  output logic [DSIZE-1:0] head_data,
  output logic             head_last
);

  logic [DSIZE-1:0] tail_data;
  logic             tail_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= '0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          if (occ == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
          occ <= occ + 2'd1;
        end
        pop && !push: begin
          head_data <= tail_data;
          head_last <= tail_last;
          occ       <= occ - 2'd1;
        end
        push && pop: begin
          // Head leaves, new word lands where the FIFO order puts it
          if (occ == 2'd1) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side engine: issues rinc, streams words out valid/ready with
// packet framing (m_last) and a word count. Optional FIFO_RD_STREAM_STALL_CNT_EN adds stall_cnt.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] rd_count
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

  occ_t          occ;
  logic          inflight;
  logic [IW-1:0] tag_idx;
  logic          head_last;
  logic          pop;
  logic          room;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && head_last;

  // Reserve a slot for every word already requested
  assign room = ({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH);
  assign rinc = rrst_n && en && !rempty && (room || pop);

  // Packet position is tagged at capture, so the head carries its own last bit
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight <= 1'b0;
      tag_idx  <= '0;
      rd_count <= '0;
    end else begin
      inflight <= rinc;
      if (inflight) begin
        tag_idx <= (tag_idx == LAST_IDX) ? '0 : tag_idx + IW'(1);
      end
      if (pop) begin
        rd_count <= rd_count + CNT_W'(1);
      end
    end
  end

  fifo_rd_skid #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .push     (inflight),
    .push_data(rdata),
    .push_last(tag_idx == LAST_IDX),
    .pop      (pop),
    .occ      (occ),
    .head_data(m_data),
    .head_last(head_last)
  );

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_cnt <= '0;
    end else if (m_ready && !m_valid && en && rempty
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`endif

endmodule
